// File: rtl/lane_deskew.sv
// Receive-side lane deskew: per-lane circular buffers whose read pointers lock on the
// COM marker, so every lane is emitted as one aligned word with a fixed latency.
module lane_deskew #(
  parameter int unsigned           NUM_LANES  = 4,
  parameter int unsigned           BITDATA    = 8,
  parameter int unsigned           MAX_SKEW   = 4,
  parameter logic [BITDATA-1:0]    COM_SYMBOL = 8'hBC
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 deskew_en,
  input  logic                                 din_valid,
  input  logic [NUM_LANES*BITDATA-1:0]         din,
  input  logic [NUM_LANES-1:0]                 din_k,
  output logic [NUM_LANES*BITDATA-1:0]         dout,
  output logic [NUM_LANES-1:0]                 dout_k,
  output logic                                 dout_valid,
  output logic                                 aligned,
  output logic                                 skew_error,
  output logic [$clog2(MAX_SKEW+1)-1:0]        skew_measured
);

  localparam int unsigned DEPTH = MAX_SKEW + 2;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned SKW_W = $clog2(MAX_SKEW + 1);
  localparam int unsigned SYM_W = BITDATA + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEARCH  = 2'd1,
    ST_ALIGNED = 2'd2
  } state_e;

  state_e                 state_q;
  logic [PTR_W-1:0]       wr_ptr_q;
  logic [PTR_W-1:0]       rd_ptr_q   [NUM_LANES];
  logic [PTR_W-1:0]       mark_ptr_q [NUM_LANES];
  logic [NUM_LANES-1:0]   seen_q;
  logic                   win_open_q;
  logic [SKW_W-1:0]       win_cnt_q;
  logic [SYM_W-1:0]       buf_q      [NUM_LANES][DEPTH];

  logic [NUM_LANES-1:0]   mark_c;
  logic [NUM_LANES-1:0]   new_mark_c;
  logic [NUM_LANES-1:0]   seen_d;
  logic [NUM_LANES-1:0]   rd_mark_c;
  logic [SYM_W-1:0]       rd_sym_c   [NUM_LANES];
  logic                   win_act_c;
  logic [SKW_W-1:0]       cur_cnt_c;
  logic                   partial_c;
  logic                   beat_c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Marker detection on the incoming beat and on the word being read out.
  always_comb begin
    mark_c    = '0;
    rd_mark_c = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      mark_c[i]    = din_k[i] && (din[i*BITDATA +: BITDATA] == COM_SYMBOL);
      rd_sym_c[i]  = buf_q[i][rd_ptr_q[i]];
      rd_mark_c[i] = rd_sym_c[i][BITDATA] && (rd_sym_c[i][BITDATA-1:0] == COM_SYMBOL);
    end
    win_act_c  = win_open_q || (|mark_c);
    cur_cnt_c  = win_open_q ? win_cnt_q + SKW_W'(1) : '0;
    new_mark_c = mark_c & ~seen_q;
    seen_d     = seen_q | new_mark_c;
    partial_c  = (|rd_mark_c) && !(&rd_mark_c);
    beat_c     = din_valid && deskew_en && (state_q != ST_IDLE);
  end

  // Buffer contents need no reset; only pointers define what is valid.
  always_ff @(posedge clk) begin
    if (beat_c) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        buf_q[i][wr_ptr_q] <= {din_k[i], din[i*BITDATA +: BITDATA]};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      wr_ptr_q      <= '0;
      seen_q        <= '0;
      win_open_q    <= 1'b0;
      win_cnt_q     <= '0;
      dout          <= '0;
      dout_k        <= '0;
      dout_valid    <= 1'b0;
      aligned       <= 1'b0;
      skew_error    <= 1'b0;
      skew_measured <= '0;
      for (int i = 0; i < NUM_LANES; i++) begin
        rd_ptr_q[i]   <= '0;
        mark_ptr_q[i] <= '0;
      end
    end else begin
      dout_valid <= 1'b0;
      skew_error <= 1'b0;
      if (!deskew_en) begin
        state_q <= ST_IDLE;
        aligned <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_q    <= ST_SEARCH;
            seen_q     <= '0;
            win_open_q <= 1'b0;
            win_cnt_q  <= '0;
          end
          ST_SEARCH: begin
            if (din_valid) begin
              wr_ptr_q <= ptr_inc(wr_ptr_q);
              for (int i = 0; i < NUM_LANES; i++) begin
                if (new_mark_c[i]) mark_ptr_q[i] <= wr_ptr_q;
              end
              if (&seen_d) begin
                // Lanes marked on this very beat are the latest; they read from wr_ptr.
                state_q       <= ST_ALIGNED;
                aligned       <= 1'b1;
                skew_measured <= cur_cnt_c;
                seen_q        <= '0;
                win_open_q    <= 1'b0;
                win_cnt_q     <= '0;
                for (int i = 0; i < NUM_LANES; i++) begin
                  rd_ptr_q[i] <= new_mark_c[i] ? wr_ptr_q : mark_ptr_q[i];
                end
              end else if (win_act_c && (cur_cnt_c == SKW_W'(MAX_SKEW))) begin
                skew_error <= 1'b1;
                seen_q     <= '0;
                win_open_q <= 1'b0;
                win_cnt_q  <= '0;
              end else begin
                seen_q     <= seen_d;
                win_open_q <= win_act_c;
                win_cnt_q  <= cur_cnt_c;
              end
            end
          end
          ST_ALIGNED: begin
            if (din_valid) begin
              wr_ptr_q <= ptr_inc(wr_ptr_q);
              if (partial_c) begin
                state_q    <= ST_SEARCH;
                aligned    <= 1'b0;
                skew_error <= 1'b1;
                seen_q     <= '0;
                win_open_q <= 1'b0;
                win_cnt_q  <= '0;
              end else begin
                dout_valid <= 1'b1;
                for (int i = 0; i < NUM_LANES; i++) begin
                  dout[i*BITDATA +: BITDATA] <= rd_sym_c[i][BITDATA-1:0];
                  dout_k[i]                  <= rd_sym_c[i][BITDATA];
                  rd_ptr_q[i]                <= ptr_inc(rd_ptr_q[i]);
                end
              end
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lane_deskew.sv
// Bench for lane_deskew: beat-indexed reference model compared every cycle, plus
// hand-computed expectations for skew values, first/last words and error pulses.
module tb_lane_deskew;

  localparam int NL = 4;
  localparam int MS = 4;

  logic        clk;
  logic        rst;
  logic        deskew_en;
  logic        din_valid;
  logic [31:0] din;
  logic [3:0]  din_k;
  logic [31:0] dout;
  logic [3:0]  dout_k;
  logic        dout_valid;
  logic        aligned;
  logic        skew_error;
  logic [2:0]  skew_measured;

  lane_deskew #(
    .NUM_LANES (4),
    .BITDATA   (8),
    .MAX_SKEW  (4),
    .COM_SYMBOL(8'hBC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .deskew_en    (deskew_en),
    .din_valid    (din_valid),
    .din          (din),
    .din_k        (din_k),
    .dout         (dout),
    .dout_k       (dout_k),
    .dout_valid   (dout_valid),
    .aligned      (aligned),
    .skew_error   (skew_error),
    .skew_measured(skew_measured)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state: absolute beat history and per-lane read positions.
  int          m_mode;
  int          nbeat;
  logic [8:0]  hist [NL][1024];
  bit          win_open;
  int          win_start;
  bit   [3:0]  m_seen;
  int          seen_at [NL];
  int          pos [NL];
  logic [31:0] e_dout;
  logic [3:0]  e_k;
  bit          e_valid, e_aligned, e_err;
  int          e_skew;
  bit          m_prev_v;

  int          n_cmp, n_bad;
  int          n_errp, n_val, stall_bad, seq_bad;
  bit          want_first, prev_al;
  logic [31:0] first_d;
  logic [3:0]  first_k;

  task automatic model_reset();
    m_mode = 0; nbeat = 0; win_open = 0; win_start = 0; m_seen = '0;
    e_dout = '0; e_k = '0; e_valid = 0; e_aligned = 0; e_err = 0; e_skew = 0;
    for (int i = 0; i < NL; i++) begin seen_at[i] = 0; pos[i] = 0; end
  endtask

  task automatic model_tick();
    logic [3:0] mk;
    logic [8:0] w [NL];
    int nm;
    e_valid  = 0;
    e_err    = 0;
    m_prev_v = din_valid;
    if (rst) begin model_reset(); return; end
    if (!deskew_en) begin m_mode = 0; e_aligned = 0; return; end
    if (m_mode == 0) begin m_mode = 1; m_seen = '0; win_open = 0; return; end
    if (!din_valid) return;
    for (int i = 0; i < NL; i++) begin
      hist[i][nbeat] = {din_k[i], din[8*i +: 8]};
      mk[i] = din_k[i] && (din[8*i +: 8] == 8'hBC);
    end
    if (m_mode == 1) begin
      if (!win_open && mk != 4'h0) begin win_open = 1; win_start = nbeat; end
      if (win_open) begin
        for (int i = 0; i < NL; i++)
          if (mk[i] && !m_seen[i]) begin m_seen[i] = 1; seen_at[i] = nbeat; end
        if (m_seen == 4'hF) begin
          m_mode = 2; e_aligned = 1; e_skew = nbeat - win_start;
          for (int i = 0; i < NL; i++) pos[i] = seen_at[i];
          m_seen = '0; win_open = 0;
        end else if (nbeat - win_start == MS) begin
          e_err = 1; m_seen = '0; win_open = 0;
        end
      end
    end else begin
      nm = 0;
      for (int i = 0; i < NL; i++) begin
        w[i] = hist[i][pos[i]];
        if (w[i][8] && w[i][7:0] == 8'hBC) nm++;
      end
      if (nm != 0 && nm != NL) begin
        e_err = 1; e_aligned = 0; m_mode = 1; m_seen = '0; win_open = 0;
      end else begin
        e_valid = 1;
        for (int i = 0; i < NL; i++) begin
          e_dout[8*i +: 8] = w[i][7:0];
          e_k[i] = w[i][8];
          pos[i]++;
        end
      end
    end
    nbeat++;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_cycle();
    int  base;
    bit  bad;
    chk("dout_valid", 64'(dout_valid), 64'(e_valid));
    chk("aligned", 64'(aligned), 64'(e_aligned));
    chk("skew_error", 64'(skew_error), 64'(e_err));
    chk("skew_measured", 64'(skew_measured), 64'(e_skew));
    if (e_valid) begin
      chk("dout", 64'(dout), 64'(e_dout));
      chk("dout_k", 64'(dout_k), 64'(e_k));
    end
    if (skew_error) n_errp++;
    if (dout_valid) n_val++;
    if (dout_valid && !m_prev_v) stall_bad++;
    if (dout_valid && want_first) begin
      first_d = dout; first_k = dout_k; want_first = 0;
    end else if (dout_valid && dout_k == 4'h0) begin
      base = int'(dout[7:0]);
      bad = 0;
      for (int i = 0; i < NL; i++)
        if (int'(dout[8*i +: 8]) - 16*i != base) bad = 1;
      if (bad) seq_bad++;
    end
    if (aligned && !prev_al) want_first = 1;
    prev_al = aligned;
  endtask

  task automatic step(input bit en, input bit v, input logic [31:0] d, input logic [3:0] k);
    deskew_en = en; din_valid = v; din = d; din_k = k;
    @(posedge clk);
    model_tick();
    @(negedge clk);
    cmp_cycle();
  endtask

  task automatic restart();
    step(0, 0, 32'h0, 4'h0);
    step(1, 0, 32'h0, 4'h0);
  endtask

  // Lane i sends filler before its COM at beat s_i, then 16*i + (beats since COM).
  task automatic run_skew(input int s0, input int s1, input int s2, input int s3,
                          input int nb, input bit stall);
    int s [NL];
    logic [31:0] d;
    logic [3:0]  k;
    s = '{s0, s1, s2, s3};
    for (int b = 0; b < nb; b++) begin
      for (int i = 0; i < NL; i++) begin
        if (b < s[i])       begin d[8*i +: 8] = 8'h0F; k[i] = 1'b0; end
        else if (b == s[i]) begin d[8*i +: 8] = 8'hBC; k[i] = 1'b1; end
        else                begin d[8*i +: 8] = 8'(16*i + b - s[i]); k[i] = 1'b0; end
      end
      step(1, 1, d, k);
      if (stall) step(1, 0, d, k);
    end
  endtask

  int e0, v0;

  initial begin
    n_cmp = 0; n_bad = 0; n_errp = 0; n_val = 0; stall_bad = 0; seq_bad = 0;
    want_first = 0; prev_al = 0; first_d = '0; first_k = '0; m_prev_v = 0;
    rst = 1'b1; deskew_en = 0; din_valid = 0; din = '0; din_k = '0;
    model_reset();
    step(0, 0, 32'h0, 4'h0);
    step(0, 0, 32'h0, 4'h0);
    rst = 1'b0;
    chk("reset_aligned", 64'(aligned), 64'd0);
    chk("reset_skew", 64'(skew_measured), 64'd0);
    chk("reset_dout", 64'(dout), 64'd0);

    // Zero skew
    restart();
    run_skew(0, 0, 0, 0, 6, 0);
    chk("zs_skew", 64'(skew_measured), 64'd0);
    chk("zs_aligned", 64'(aligned), 64'd1);
    chk("zs_first", 64'(first_d), 64'hBCBCBCBC);
    chk("zs_first_k", 64'(first_k), 64'hF);
    chk("zs_last", 64'(dout), 64'h34241404);

    // Skew 3
    restart();
    run_skew(0, 1, 2, 3, 10, 0);
    chk("s3_skew", 64'(skew_measured), 64'd3);
    chk("s3_first", 64'(first_d), 64'hBCBCBCBC);
    chk("s3_last", 64'(dout), 64'h35251505);

    // Window expiry
    restart();
    e0 = n_errp; v0 = n_val;
    run_skew(0, 0, 0, 5, 8, 0);
    chk("exp_err_pulses", 64'(n_errp - e0), 64'd1);
    chk("exp_no_valid", 64'(n_val - v0), 64'd0);
    chk("exp_aligned", 64'(aligned), 64'd0);

    // Lock loss then re-lock
    restart();
    run_skew(0, 1, 1, 1, 6, 0);
    chk("ll_skew", 64'(skew_measured), 64'd1);
    e0 = n_errp;
    step(1, 1, 32'h35BC1506, 4'b0100);
    step(1, 1, 32'h37271707, 4'b0000);
    chk("ll_err", 64'(skew_error), 64'd1);
    chk("ll_aligned", 64'(aligned), 64'd0);
    chk("ll_suppressed", 64'(dout_valid), 64'd0);
    chk("ll_pulses", 64'(n_errp - e0), 64'd1);
    run_skew(0, 0, 0, 0, 4, 0);
    chk("relock_aligned", 64'(aligned), 64'd1);
    chk("relock_skew", 64'(skew_measured), 64'd0);
    chk("relock_first", 64'(first_d), 64'hBCBCBCBC);

    // Stalled skew-2 lock
    restart();
    run_skew(0, 2, 1, 2, 8, 1);
    chk("st_skew", 64'(skew_measured), 64'd2);
    chk("st_first", 64'(first_d), 64'hBCBCBCBC);
    chk("st_last", 64'(dout), 64'h34241404);
    chk("st_no_stall_valid", 64'(stall_bad), 64'd0);

    // Asynchronous reset while aligned
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("ar_dout", 64'(dout), 64'd0);
    chk("ar_dout_k", 64'(dout_k), 64'd0);
    chk("ar_valid", 64'(dout_valid), 64'd0);
    chk("ar_aligned", 64'(aligned), 64'd0);
    chk("ar_err", 64'(skew_error), 64'd0);
    chk("ar_skew", 64'(skew_measured), 64'd0);
    step(0, 0, 32'h0, 4'h0);
    rst = 1'b0;

    // Disable while aligned
    restart();
    run_skew(0, 0, 0, 0, 4, 0);
    chk("dis_pre_aligned", 64'(aligned), 64'd1);
    e0 = n_errp;
    step(0, 1, 32'h34241404, 4'h0);
    chk("dis_aligned", 64'(aligned), 64'd0);
    chk("dis_valid", 64'(dout_valid), 64'd0);
    chk("dis_err", 64'(n_errp - e0), 64'd0);
    step(0, 0, 32'h0, 4'h0);
    chk("dis_skew_held", 64'(skew_measured), 64'd0);

    chk("seq_consistent", 64'(seq_bad), 64'd0);
    chk("stall_valid_total", 64'(stall_bad), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
